// File: rtl/producer_pkg.sv
// Shared encodings for the producer arbiter: FSM states, display codes and LED patterns.
package producer_pkg;

  // One-hot states so that any corrupted encoding is detectable and decodes to IDLE.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_RUN   = 4'b0010,
    S_WAIT  = 4'b0100,
    S_DRAIN = 4'b1000
  } state_t;

  localparam logic [1:0] MOD_NONE = 2'b00;
  localparam logic [1:0] MOD_F    = 2'b01;
  localparam logic [1:0] MOD_T    = 2'b11;

  localparam logic [3:0] LED_IDLE  = 4'b0001;
  localparam logic [3:0] LED_RUN   = 4'b0010;
  localparam logic [3:0] LED_WAIT  = 4'b0100;
  localparam logic [3:0] LED_DRAIN = 4'b1000;

  function automatic logic [1:0] mod_code(input logic g);
    if (g) begin
      return MOD_T;
    end else begin
      return MOD_F;
    end
  endfunction

endpackage

// File: rtl/producer_arbiter_rr_slice_counter.sv
// Round-robin slice counter: owns the grant bit and counts accepted words within a slice.
module rr_slice_counter #(
  parameter int SLICE = 4,
  parameter int CNT_W = $clog2(SLICE) + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic load_grant,
  input  logic accept,
  input  logic other_active,
  input  logic force_switch,
  output logic grant,
  output logic rotate
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             grant_r;

  assign rotate = accept & (cnt_r == CNT_LAST);
  assign grant  = grant_r;

  // Grant/count update: load beats a forced switch, which beats normal slice accounting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r   <= CNT_ZERO;
      grant_r <= 1'b0;
    end else if (load) begin
      cnt_r   <= CNT_ZERO;
      grant_r <= load_grant;
    end else if (force_switch) begin
      cnt_r   <= CNT_ZERO;
      grant_r <= ~grant_r;
    end else if (rotate) begin
      cnt_r   <= CNT_ZERO;
      grant_r <= other_active ? ~grant_r : grant_r;
    end else if (accept) begin
      cnt_r   <= cnt_r + CNT_ONE;
      grant_r <= grant_r;
    end else begin
      cnt_r   <= cnt_r;
      grant_r <= grant_r;
    end
  end

endmodule

// File: rtl/producer_arbiter.sv
// Shares the wrapper write port between the Fibonacci (0) and timer (1) producers,
// rotating the grant every SLICE accepted words and stalling on a full buffer.
module producer_arbiter
  import producer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int CNT_W = $clog2(SLICE) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_0,
  input  logic             start_1,
  input  logic             stop_0,
  input  logic             stop_1,
  input  logic             valid_0,
  input  logic             valid_1,
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  input  logic             buffer_full,
  input  logic             buffer_empty,
  input  logic             data_2_valid,
  output logic             en_0,
  output logic             en_1,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             grant,
  output logic [1:0]       module_sig,
  output logic [3:0]       led
);

  state_t state_r;
  state_t state_n_s;
  logic   active_0_r;
  logic   active_1_r;
  logic   active_0_n_s;
  logic   active_1_n_s;
  logic   go_0_s;
  logic   go_1_s;
  logic   run_a0_s;
  logic   run_a1_s;
  logic   load_s;
  logic   load_grant_s;
  logic   force_switch_s;
  logic   other_active_s;
  logic   grant_s;
  logic   wr_en_s;
  logic   unused_rotate_s;

  // A stop in the same cycle always wins over a start of the same producer.
  assign go_0_s   = start_0 & ~stop_0;
  assign go_1_s   = start_1 & ~stop_1;
  assign run_a0_s = go_0_s | (active_0_r & ~stop_0);
  assign run_a1_s = go_1_s | (active_1_r & ~stop_1);
  assign other_active_s = grant_s ? run_a0_s : run_a1_s;

  rr_slice_counter #(
    .SLICE (SLICE),
    .CNT_W (CNT_W)
  ) u_rr_slice_counter (
    .clock        (clock),
    .reset        (reset),
    .load         (load_s),
    .load_grant   (load_grant_s),
    .accept       (wr_en_s),
    .other_active (other_active_s),
    .force_switch (force_switch_s),
    .grant        (grant_s),
    .rotate       (unused_rotate_s)
  );

  // State and activity registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      active_0_r <= 1'b0;
      active_1_r <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      active_0_r <= active_0_n_s;
      active_1_r <= active_1_n_s;
    end
  end

  // Next-state, activity and grant-control decode.
  always_comb begin
    state_n_s      = state_r;
    active_0_n_s   = active_0_r;
    active_1_n_s   = active_1_r;
    load_s         = 1'b0;
    load_grant_s   = 1'b0;
    force_switch_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (go_0_s | go_1_s) begin
          active_0_n_s = go_0_s;
          active_1_n_s = go_1_s;
          load_s       = 1'b1;
          load_grant_s = ~go_0_s;
          state_n_s    = S_RUN;
        end else begin
          state_n_s    = S_IDLE;
        end
      end
      S_RUN, S_WAIT: begin
        active_0_n_s = run_a0_s;
        active_1_n_s = run_a1_s;
        if (!run_a0_s && !run_a1_s) begin
          state_n_s = S_DRAIN;
        end else begin
          // Stopping the granted producer hands the port straight to the other one.
          force_switch_s = grant_s ? (stop_1 & run_a0_s) : (stop_0 & run_a1_s);
          state_n_s      = buffer_full ? S_WAIT : S_RUN;
        end
      end
      S_DRAIN: begin
        active_0_n_s = 1'b0;
        active_1_n_s = 1'b0;
        if (buffer_empty && !data_2_valid) begin
          state_n_s = S_IDLE;
        end else begin
          state_n_s = S_DRAIN;
        end
      end
      default: begin
        state_n_s    = S_IDLE;
        active_0_n_s = 1'b0;
        active_1_n_s = 1'b0;
      end
    endcase
  end

  // Output decode from registered state plus the granted producer's valid/data.
  always_comb begin
    en_0       = 1'b0;
    en_1       = 1'b0;
    wr_en_s    = 1'b0;
    wr_data    = {WIDTH{1'b0}};
    module_sig = MOD_NONE;
    led        = LED_IDLE;
    case (state_r)
      S_IDLE: begin
        led = LED_IDLE;
      end
      S_RUN: begin
        led        = LED_RUN;
        en_0       = ~grant_s;
        en_1       = grant_s;
        module_sig = mod_code(grant_s);
        wr_en_s    = grant_s ? (valid_1 & active_1_r) : (valid_0 & active_0_r);
        if (wr_en_s) begin
          wr_data = grant_s ? data_1 : data_0;
        end else begin
          wr_data = {WIDTH{1'b0}};
        end
      end
      S_WAIT: begin
        led        = LED_WAIT;
        module_sig = mod_code(grant_s);
      end
      S_DRAIN: begin
        led = LED_DRAIN;
      end
      default: begin
        led = LED_IDLE;
      end
    endcase
  end

  assign wr_en = wr_en_s;
  assign grant = grant_s;

endmodule

// File: doc/producer_arbiter.md
Name: producer_arbiter

Overview:
Shares the GALS wrapper's single write port between the Fibonacci and timer producers, so both can stream at once. Only one producer is enabled at a time. Grants rotate round-robin after SLICE accepted words. Stalls on buffer_full; individual stops drain the buffer before IDLE. Sits in top between the producers and the wrapper, replacing the single-source COMM/WAIT sequencing.

Parameters:
WIDTH, 16, producer/buffer data width
SLICE, 4, words accepted from one producer before the grant may rotate (>=1)
CNT_W, $clog2(SLICE)+1, slice counter width

Ports:
clock  in  1  system clock; all inputs synchronous to it
reset  in  1  asynchronous, active-high
start_0  in  1  one-cycle pulse (edge-detected); activate producer 0 (fibonacci)
start_1  in  1  one-cycle pulse; activate producer 1 (timer)
stop_0  in  1  one-cycle pulse; deactivate producer 0
stop_1  in  1  one-cycle pulse; deactivate producer 1
valid_0  in  1  producer 0 word valid
valid_1  in  1  producer 1 word valid
data_0  in  WIDTH  producer 0 word
data_1  in  WIDTH  producer 1 word
buffer_full  in  1  wrapper FIFO full
buffer_empty  in  1  wrapper FIFO empty
data_2_valid  in  1  consumer side still presenting a word
en_0  out  1  enable producer 0
en_1  out  1  enable producer 1
wr_en  out  1  write strobe to wrapper (data_1_en)
wr_data  out  WIDTH  write data to wrapper
grant  out  1  currently granted producer
module_sig  out  2  display code: 00 none, 01 producer 0, 11 producer 1
led  out  4  one-hot state: IDLE=0001, RUN=0010, WAIT=0100, DRAIN=1000

Behaviour:
- Registers: state, active_0, active_1, grant, cnt. Reset: state=IDLE, active_*=0, grant=0, cnt=0.
- All outputs are combinational from registers plus valid/data. Values at reset: en_*=0, wr_en=0, wr_data=0, module_sig=00, led=0001.
- IDLE: start_x sets active_x and goes to RUN with grant=x. If start_0 and start_1 arrive together, both become active and grant=0.
- RUN:
  - en_g=1 for the granted producer g only.
  - wr_en = valid_g & active_g; wr_data = data_g when wr_en is 1, else 0.
  - module_sig = 01 when g=0, 11 when g=1.
- Rotation: on each wr_en, cnt increments. When wr_en and cnt==SLICE-1:
  - cnt returns to 0.
  - If the other producer is active, grant flips; otherwise grant holds.
- Backpressure: buffer_full in RUN moves to WAIT next cycle. A wr_en in that same cycle is still issued; the wrapper's full flag covers it.
- WAIT: en_*=0, wr_en=0, grant and cnt held. Returns to RUN the cycle after buffer_full deasserts.
- start_x in RUN or WAIT sets active_x with no grant change. Starting an already-active producer has no effect.
- stop_x in RUN or WAIT clears active_x.
  - If x is granted and the other producer is active: grant flips and cnt=0 next cycle.
  - If neither producer remains active: go to DRAIN.
- Same-cycle priority: stop_x beats start_x. stop_0 and stop_1 together go to DRAIN.
- Any wr_en already issued in the stop cycle is kept.
- DRAIN: en_*=0, wr_en=0, module_sig=00. All starts are ignored. Goes to IDLE when buffer_empty & !data_2_valid.
- Reset mid-operation: immediate return to reset values. An in-flight word is not written.
- Illegal state encodings decode to IDLE with IDLE outputs.

Decomposition:
- Shared package (producer_pkg): state encodings S_IDLE/S_RUN/S_WAIT/S_DRAIN, module_sig codes MOD_NONE=00, MOD_F=01, MOD_T=11, and LED one-hot constants.
- One natural sub-module: rr_slice_counter. It holds cnt and grant, takes accept, other_active and force_switch, and outputs grant plus a rotate pulse.

Test Plan:
- Reset then start_0 pulse, valid_0 every cycle, data_0=1,1,2,3 -> RUN, grant=0, en_0=1, wr_data sequence 1,1,2,3, led=0010, module_sig=01.
- Both started, SLICE=4, both valid continuously -> exactly 4 writes from producer 0, then 4 from producer 1, repeating. en_0 and en_1 never high together.
- In RUN, buffer_full=1 for 5 cycles -> WAIT (led=0100), wr_en=0 throughout. After full drops, RUN resumes with the same grant and cnt unchanged.
- Both active, grant=1, stop_1 pulse -> next cycle grant=0, cnt=0, en_0=1. A following stop_0 -> DRAIN, led=1000.
- DRAIN with buffer_empty=0, then buffer_empty=1 and data_2_valid=1, then both clear -> IDLE only on the last condition. start_0 during DRAIN is ignored.
- Simultaneous start_0 and stop_0 in RUN with producer 1 active -> active_0 stays 0. Simultaneous start_0 and start_1 in IDLE -> grant=0, both active.
